// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD bus blocks (reader and writer).
package lcd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_EN_HIGH,
      ST_RECOVER
   } lcd_state_t;

   localparam logic RS_INSTR = 1'b0;
   localparam logic RS_DATA  = 1'b1;
   localparam int   BF_BIT   = 7;

   // Instruction bytes shared with the command/text writer
   localparam logic [7:0] CMD_CLEAR       = 8'h01;
   localparam logic [7:0] CMD_HOME        = 8'h02;
   localparam logic [7:0] CMD_ENTRY_MODE  = 8'h06;
   localparam logic [7:0] CMD_DISPLAY_ON  = 8'h0C;
   localparam logic [7:0] CMD_FUNC_SET_8B = 8'h38;
   localparam logic [7:0] CMD_SET_DDRAM   = 8'h80;
   localparam logic [7:0] CMD_SET_CGRAM   = 8'h40;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module lcd_phase_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/lcd_bus_reader.sv
// Read side of the HD44780 8-bit bus: status/busy polling and DDRAM/CGRAM reads.
// Optional poll abandonment after POLL_MAX busy reads: define LCD_BUSY_TIMEOUT_EN.
module lcd_bus_reader #(
   parameter int DATA_BITS = 8,
   parameter int T_AS      = 4,
   parameter int T_PW      = 25,
   parameter int T_REC     = 50,
   parameter int POLL_MAX  = 65535
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_i,
   input  logic                 rs_sel_i,
   input  logic                 poll_i,
   output logic                 ready_o,
   output logic                 rd_valid_o,
   output logic [DATA_BITS-1:0] rd_data_o,
   output logic                 timeout_o,
   output logic                 lcd_rs,
   output logic                 lcd_rw,
   output logic                 lcd_en,
   input  logic [DATA_BITS-1:0] lcd_dat_i,
   output logic                 lcd_dat_oe
);

   import lcd_pkg::*;

   localparam int CW = $clog2(max3(T_AS, T_PW, T_REC)) + 1;

   lcd_state_t           state;
   logic                 rs_q;
   logic                 poll_q;
   logic [DATA_BITS-1:0] sample;
   logic                 tmr_load;
   logic [CW-1:0]        tmr_val;
   logic                 tmr_done;
   logic                 busy_poll;
   logic                 expire;
   logic                 reread;

`ifdef LCD_BUSY_TIMEOUT_EN
   localparam int PCW = $clog2(POLL_MAX + 1);
   // Counts status reads already finished in this request, excluding the current one
   logic [PCW-1:0] poll_cnt;
   assign expire = (poll_cnt == PCW'(POLL_MAX - 1));
`else
   assign expire = 1'b0;
`endif

   assign busy_poll  = poll_q && (rs_q == RS_INSTR) && sample[BF_BIT];
   assign reread     = busy_poll && !expire;
   assign lcd_dat_oe = 1'b0;

   // Timer reload at every phase transition, so each phase's first cycle sees N-1
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state)
         ST_IDLE: if (req_i) begin
            tmr_load = 1'b1;
            tmr_val  = CW'(T_AS - 1);
         end
         ST_SETUP: if (tmr_done) begin
            tmr_load = 1'b1;
            tmr_val  = CW'(T_PW - 1);
         end
         ST_EN_HIGH: if (tmr_done) begin
            tmr_load = 1'b1;
            tmr_val  = CW'(T_REC - 1);
         end
         ST_RECOVER: if (tmr_done && reread) begin
            tmr_load = 1'b1;
            tmr_val  = CW'(T_AS - 1);
         end
         default: ;
      endcase
   end

   lcd_phase_timer #(.W(CW)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         ready_o    <= 1'b1;
         rd_valid_o <= 1'b0;
         timeout_o  <= 1'b0;
         rd_data_o  <= '0;
         lcd_rs     <= 1'b0;
         lcd_rw     <= 1'b0;
         lcd_en     <= 1'b0;
         rs_q       <= 1'b0;
         poll_q     <= 1'b0;
         sample     <= '0;
`ifdef LCD_BUSY_TIMEOUT_EN
         poll_cnt   <= '0;
`endif
      end else begin
         rd_valid_o <= 1'b0;
         timeout_o  <= 1'b0;
         case (state)
            ST_IDLE: if (req_i) begin
               rs_q    <= rs_sel_i;
               poll_q  <= poll_i;
               lcd_rs  <= rs_sel_i;
               lcd_rw  <= 1'b1;
               ready_o <= 1'b0;
               state   <= ST_SETUP;
`ifdef LCD_BUSY_TIMEOUT_EN
               poll_cnt <= '0;
`endif
            end
            ST_SETUP: if (tmr_done) begin
               lcd_en <= 1'b1;
               state  <= ST_EN_HIGH;
            end
            ST_EN_HIGH: if (tmr_done) begin
               lcd_en <= 1'b0;
               sample <= lcd_dat_i;
               state  <= ST_RECOVER;
            end
            ST_RECOVER: if (tmr_done) begin
               if (reread) begin
                  state <= ST_SETUP;
`ifdef LCD_BUSY_TIMEOUT_EN
                  poll_cnt <= poll_cnt + 1'b1;
`endif
               end else begin
                  rd_data_o  <= sample;
                  rd_valid_o <= 1'b1;
                  timeout_o  <= busy_poll && expire;
                  ready_o    <= 1'b1;
                  lcd_rw     <= 1'b0;
                  state      <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Randomized bench for lcd_bus_reader against a per-request reference model.
module tb_lcd_bus_reader;

   localparam int T_AS     = 4;
   localparam int T_PW     = 25;
   localparam int T_REC    = 50;
   localparam int POLL_MAX = 4;
   localparam int ACC      = T_AS + T_PW + T_REC;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req_i = 1'b0;
   logic       rs_sel_i = 1'b0;
   logic       poll_i = 1'b0;
   logic       ready_o, rd_valid_o, timeout_o;
   logic [7:0] rd_data_o;
   logic       lcd_rs, lcd_rw, lcd_en, lcd_dat_oe;
   logic [7:0] lcd_dat_i = 8'h00;

   int n_assert = 0;
   int n_fail   = 0;

   logic [7:0] byte_q[$];
   int         e_pulses;
   logic [7:0] e_data;
   logic       e_tmo;

   int         m_valid_cyc, m_pulses, m_first_rise, m_en_min, m_en_max, m_gap_min;
   int         m_rs_bad, m_rw_bad, m_oe_bad;
   logic [7:0] m_data;
   logic       m_tmo, m_ready, m_rw_end, m_data_changed;

   always #5 clk = ~clk;

   lcd_bus_reader #(
      .DATA_BITS (8),
      .T_AS      (T_AS),
      .T_PW      (T_PW),
      .T_REC     (T_REC),
      .POLL_MAX  (POLL_MAX)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_i      (req_i),
      .rs_sel_i   (rs_sel_i),
      .poll_i     (poll_i),
      .ready_o    (ready_o),
      .rd_valid_o (rd_valid_o),
      .rd_data_o  (rd_data_o),
      .timeout_o  (timeout_o),
      .lcd_rs     (lcd_rs),
      .lcd_rw     (lcd_rw),
      .lcd_en     (lcd_en),
      .lcd_dat_i  (lcd_dat_i),
      .lcd_dat_oe (lcd_dat_oe)
   );

   // Each E pulse consumes the next byte; polls stop on BF=0 (or at POLL_MAX with the timeout build)
   function automatic void model(input logic rs, input logic poll);
      e_pulses = 0;
      e_tmo    = 1'b0;
      e_data   = 8'h00;
      for (int i = 0; i < byte_q.size(); i++) begin
         e_pulses = i + 1;
         e_data   = byte_q[i];
         if (rs || !poll || !byte_q[i][7]) break;
`ifdef LCD_BUSY_TIMEOUT_EN
         if (e_pulses == POLL_MAX) begin
            e_tmo = 1'b1;
            break;
         end
`endif
      end
   endfunction

   // Issues one request and measures the bus activity until rd_valid_o or the cycle budget
   task automatic run_access(input logic rs, input logic poll, input bit jitter, input int exp_cyc);
      int   idx = 0, high_run = 0, low_run = 0;
      logic prev_en = 1'b0;
      logic [7:0] start_data;
      @(negedge clk);
      start_data = rd_data_o;
      req_i = 1'b1; rs_sel_i = rs; poll_i = poll;
      m_valid_cyc = -1; m_pulses = 0; m_first_rise = -1;
      m_en_min = 1 << 30; m_en_max = 0; m_gap_min = 1 << 30;
      m_rs_bad = 0; m_rw_bad = 0; m_oe_bad = 0; m_data_changed = 1'b0;
      m_data = 8'h00; m_tmo = 1'b0; m_ready = 1'b0; m_rw_end = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= exp_cyc + 20 && m_valid_cyc < 0; c++) begin
         @(negedge clk);
         if (jitter && c < exp_cyc - 1) begin
            req_i = 1'($urandom); rs_sel_i = 1'($urandom); poll_i = 1'($urandom);
         end else begin
            req_i = 1'b0;
         end
         if (lcd_en && !prev_en) begin
            m_pulses++;
            if (m_pulses == 1) m_first_rise = c;
            else if (low_run < m_gap_min) m_gap_min = low_run;
            high_run = 1;
            lcd_dat_i = (idx < byte_q.size()) ? byte_q[idx] : 8'($urandom);
            idx++;
         end else if (lcd_en) begin
            high_run++;
         end else if (prev_en) begin
            if (high_run < m_en_min) m_en_min = high_run;
            if (high_run > m_en_max) m_en_max = high_run;
            low_run = 1;
            lcd_dat_i = 8'($urandom);
         end else begin
            low_run++;
            lcd_dat_i = 8'($urandom);
         end
         prev_en = lcd_en;
         if (lcd_dat_oe !== 1'b0) m_oe_bad++;
         if (rd_valid_o) begin
            m_valid_cyc = c; m_data = rd_data_o; m_tmo = timeout_o;
            m_ready = ready_o; m_rw_end = lcd_rw;
         end else begin
            if (lcd_rw !== 1'b1) m_rw_bad++;
            if (lcd_rs !== rs) m_rs_bad++;
            if (rd_data_o !== start_data) m_data_changed = 1'b1;
         end
      end
      req_i = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_assert++;
      if ({ready_o, rd_valid_o, timeout_o, lcd_rs, lcd_rw, lcd_en, lcd_dat_oe} !== 7'b1000000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b want 1000000",
                  {ready_o, rd_valid_o, timeout_o, lcd_rs, lcd_rw, lcd_en, lcd_dat_oe});
      end
      n_assert++;
      if (rd_data_o !== 8'h00) begin
         n_fail++; $display("FAIL reset_data: got %h want 00", rd_data_o);
      end
      reset = 1'b0;
   endtask

   task automatic test_abort();
      int stray = 0;
      @(negedge clk);
      req_i = 1'b1; rs_sel_i = 1'b0; poll_i = 1'b1; lcd_dat_i = 8'hC3;
      @(posedge clk);
      for (int c = 1; c <= T_AS + 10; c++) begin
         @(negedge clk);
         req_i = 1'b0;
      end
      n_assert++;
      if (lcd_en !== 1'b1) begin
         n_fail++; $display("FAIL abort_en_before: got %b want 1", lcd_en);
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      n_assert++;
      if ({lcd_en, lcd_rw, ready_o, rd_valid_o} !== 4'b0010 || rd_data_o !== 8'h00) begin
         n_fail++;
         $display("FAIL abort_state: en/rw/ready/valid=%b data=%h want 0010 data=00",
                  {lcd_en, lcd_rw, ready_o, rd_valid_o}, rd_data_o);
      end
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 2 * ACC; c++) begin
         @(negedge clk);
         if (rd_valid_o || lcd_en || !ready_o) stray++;
      end
      n_assert++;
      if (stray != 0) begin
         n_fail++; $display("FAIL abort_quiet: %0d active cycles after abort, want 0", stray);
      end
   endtask

   task automatic test_status();
      byte_q = '{8'h23};
      model(1'b0, 1'b0);
      run_access(1'b0, 1'b0, 1'b0, e_pulses * ACC + 1);
      n_assert++;
      if (m_valid_cyc != e_pulses * ACC + 1) begin
         n_fail++; $display("FAIL status_latency: got %0d want %0d", m_valid_cyc, e_pulses * ACC + 1);
      end
      n_assert++;
      if (m_data !== e_data) begin
         n_fail++; $display("FAIL status_data: got %h want %h", m_data, e_data);
      end
      n_assert++;
      if (m_pulses != 1 || m_en_min != T_PW || m_en_max != T_PW || m_first_rise != T_AS + 1) begin
         n_fail++;
         $display("FAIL status_en: pulses=%0d width=%0d..%0d rise=%0d want 1 %0d..%0d %0d",
                  m_pulses, m_en_min, m_en_max, m_first_rise, T_PW, T_PW, T_AS + 1);
      end
      n_assert++;
      if (m_rs_bad != 0 || m_rw_bad != 0 || m_oe_bad != 0) begin
         n_fail++;
         $display("FAIL status_bus: rs_bad=%0d rw_bad=%0d oe_bad=%0d want 0", m_rs_bad, m_rw_bad, m_oe_bad);
      end
      n_assert++;
      if (m_ready !== 1'b1 || m_rw_end !== 1'b0 || m_tmo !== 1'b0) begin
         n_fail++;
         $display("FAIL status_end: ready=%b rw=%b timeout=%b want 1 0 0", m_ready, m_rw_end, m_tmo);
      end
   endtask

   task automatic test_data_read();
      byte_q = '{8'h41, 8'h85};
      model(1'b1, 1'b1);
      run_access(1'b1, 1'b1, 1'b0, e_pulses * ACC + 1);
      n_assert++;
      if (m_pulses != 1 || m_data !== 8'h41 || m_rs_bad != 0) begin
         n_fail++;
         $display("FAIL data_read: pulses=%0d data=%h rs_bad=%0d want 1 41 0", m_pulses, m_data, m_rs_bad);
      end
      n_assert++;
      if (m_valid_cyc != e_pulses * ACC + 1) begin
         n_fail++; $display("FAIL data_latency: got %0d want %0d", m_valid_cyc, e_pulses * ACC + 1);
      end
   endtask

   task automatic test_poll();
      byte_q = '{8'h85, 8'h85, 8'h85, 8'h05};
      model(1'b0, 1'b1);
      run_access(1'b0, 1'b1, 1'b0, e_pulses * ACC + 1);
      n_assert++;
      if (m_pulses != 4 || m_data !== 8'h05 || m_tmo !== 1'b0) begin
         n_fail++;
         $display("FAIL poll_result: pulses=%0d data=%h timeout=%b want 4 05 0", m_pulses, m_data, m_tmo);
      end
      n_assert++;
      if (m_gap_min < T_REC || m_en_min != T_PW || m_en_max != T_PW) begin
         n_fail++;
         $display("FAIL poll_timing: min_gap=%0d width=%0d..%0d want gap>=%0d width=%0d",
                  m_gap_min, m_en_min, m_en_max, T_REC, T_PW);
      end
      n_assert++;
      if (m_valid_cyc != e_pulses * ACC + 1 || m_data_changed) begin
         n_fail++;
         $display("FAIL poll_valid: cycle=%0d data_changed=%b want %0d 0",
                  m_valid_cyc, m_data_changed, e_pulses * ACC + 1);
      end
   endtask

   task automatic test_poll_limit();
      byte_q.delete();
`ifdef LCD_BUSY_TIMEOUT_EN
      for (int i = 0; i < POLL_MAX + 4; i++) byte_q.push_back(8'h80);
`else
      for (int i = 0; i < POLL_MAX + 2; i++) byte_q.push_back(8'h80 | 8'($urandom_range(0, 127)));
      byte_q.push_back(8'h1F);
`endif
      model(1'b0, 1'b1);
      run_access(1'b0, 1'b1, 1'b0, e_pulses * ACC + 1);
      n_assert++;
      if (m_pulses != e_pulses || m_data !== e_data || m_tmo !== e_tmo) begin
         n_fail++;
         $display("FAIL poll_limit: pulses=%0d data=%h timeout=%b want %0d %h %b",
                  m_pulses, m_data, m_tmo, e_pulses, e_data, e_tmo);
      end
      n_assert++;
      if (m_valid_cyc != e_pulses * ACC + 1) begin
         n_fail++; $display("FAIL poll_limit_latency: got %0d want %0d", m_valid_cyc, e_pulses * ACC + 1);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 8; it++) begin
         logic rs, poll;
         int   nbusy;
         rs = 1'($urandom); poll = 1'($urandom);
         nbusy = $urandom_range(0, 5);
         byte_q.delete();
         for (int i = 0; i < nbusy; i++) byte_q.push_back(8'h80 | 8'($urandom_range(0, 127)));
         byte_q.push_back(8'($urandom_range(0, 127)));
         model(rs, poll);
         run_access(rs, poll, 1'b1, e_pulses * ACC + 1);
         n_assert++;
         if (m_valid_cyc != e_pulses * ACC + 1 || m_pulses != e_pulses || m_data !== e_data ||
             m_tmo !== e_tmo || m_rs_bad != 0) begin
            n_fail++;
            $display("FAIL random_%0d: cyc=%0d pulses=%0d data=%h tmo=%b rs_bad=%0d want %0d %0d %h %b 0",
                     it, m_valid_cyc, m_pulses, m_data, m_tmo, m_rs_bad,
                     e_pulses * ACC + 1, e_pulses, e_data, e_tmo);
         end
      end
   endtask

   task automatic test_back_to_back();
      int   valid_cyc[$], rise_cyc[$];
      int   idx = 0, bad = 0;
      logic prev_en = 1'b0;
      byte_q.delete();
      for (int i = 0; i < 3; i++) byte_q.push_back(8'($urandom));
      @(negedge clk);
      req_i = 1'b1; rs_sel_i = 1'b1; poll_i = 1'b0;
      @(posedge clk);
      for (int c = 1; c <= 3 * (ACC + 1) + 5; c++) begin
         @(negedge clk);
         if (lcd_en && !prev_en) begin
            rise_cyc.push_back(c);
            lcd_dat_i = (idx < 3) ? byte_q[idx] : 8'($urandom);
            idx++;
         end else if (!lcd_en) begin
            lcd_dat_i = 8'($urandom);
         end
         prev_en = lcd_en;
         if (rd_valid_o) begin
            if (valid_cyc.size() < 3 && rd_data_o !== byte_q[valid_cyc.size()]) bad++;
            valid_cyc.push_back(c);
            if (valid_cyc.size() == 3) req_i = 1'b0;
         end
      end
      req_i = 1'b0;
      n_assert++;
      if (valid_cyc.size() != 3 || rise_cyc.size() != 3 || bad != 0) begin
         n_fail++;
         $display("FAIL b2b_count: valids=%0d pulses=%0d bad_data=%0d want 3 3 0",
                  valid_cyc.size(), rise_cyc.size(), bad);
      end else begin
         for (int k = 0; k < 3; k++) begin
            n_assert++;
            if (valid_cyc[k] != (k + 1) * (ACC + 1) || rise_cyc[k] != k * (ACC + 1) + T_AS + 1) begin
               n_fail++;
               $display("FAIL b2b_timing_%0d: valid=%0d rise=%0d want %0d %0d", k, valid_cyc[k],
                        rise_cyc[k], (k + 1) * (ACC + 1), k * (ACC + 1) + T_AS + 1);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_abort();
      test_status();
      test_data_read();
      test_poll();
      test_poll_limit();
      test_random();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
